// File: rtl/microprocessor_host_sequencer_pkg.sv
// Shared definitions for the microprocessor host sequencer: state encodings,
// arithmetic opcode constants and the default idle microaddress.
package microprocessor_host_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_BUSY    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_RESPOND = 3'd4
  } seq_state_e;

  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1100;

  localparam logic [7:0] DEFAULT_IDLE_UADDR = 8'h00;

endpackage

// File: rtl/microprocessor_host_sequencer_timer.sv
// Loadable down-counter shared by the GO_BAR hold interval and the
// remaining timeout window; done is high while the count is zero.
module host_sequencer_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count_r;

  // Count register: load wins over decrement, and the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - WIDTH'(1);
    end
  end

  assign done = (count_r == '0);

endmodule

// File: rtl/microprocessor_host_sequencer.sv
// Host-side command initiator: launches one arithmetic request on the
// microprocessor, detects completion or timeout, and returns the result.
module microprocessor_host_sequencer
  import microprocessor_host_sequencer_pkg::*;
#(
  parameter logic [7:0] IDLE_UADDR = DEFAULT_IDLE_UADDR,
  parameter int         GO_HOLD    = 6,
  parameter int         TIMEOUT    = 64
) (
  input  logic       SYSTEM_CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [3:0] REQ_OPCODE,
  input  logic [7:0] REQ_A,
  input  logic [7:0] REQ_B,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_DATA,
  output logic [3:0] RSP_OPCODE,
  output logic       RSP_TIMEOUT,
  output logic [3:0] OPCODE,
  output logic [7:0] DATA_IN_A,
  output logic [7:0] DATA_IN_B,
  output logic       GO_BAR,
  output logic       JAM,
  input  logic [7:0] MICROADDRESS,
  input  logic [7:0] DATA_OUT
);

  // The timer is reloaded on entry to BUSY with what is left of the timeout
  // window, so one counter covers both intervals.
  localparam logic [15:0] HOLD_LOAD = 16'(GO_HOLD - 1);
  localparam logic [15:0] BUSY_LOAD = 16'(TIMEOUT - 1 - GO_HOLD);

  seq_state_e  state_r, next_state_s;
  logic        left_r;
  logic        req_ready_r, go_bar_r, jam_r, rsp_valid_r, rsp_timeout_r;
  logic [3:0]  opcode_r, rsp_opcode_r;
  logic [7:0]  data_a_r, data_b_r, rsp_data_r;
  logic        accept_s, complete_s, timer_done_s;
  logic        timer_load_s, timer_en_s;
  logic [15:0] timer_load_value_s;

  assign accept_s   = (state_r == ST_IDLE) && REQ_VALID && req_ready_r;
  assign complete_s = (state_r == ST_BUSY) && left_r && (MICROADDRESS == IDLE_UADDR);

  host_sequencer_timer #(.WIDTH(16)) u_timer (
    .clk        (SYSTEM_CLK),
    .rst_n      (RESET),
    .load       (timer_load_s),
    .load_value (timer_load_value_s),
    .en         (timer_en_s),
    .done       (timer_done_s)
  );

  // Next-state and timer control; completion takes priority over timeout.
  always_comb begin
    next_state_s       = state_r;
    timer_load_s       = 1'b0;
    timer_load_value_s = HOLD_LOAD;
    timer_en_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_LAUNCH;
          timer_load_s = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        timer_en_s = 1'b1;
        if (timer_done_s) begin
          next_state_s       = ST_BUSY;
          timer_load_s       = 1'b1;
          timer_load_value_s = BUSY_LOAD;
        end else begin
          next_state_s = ST_LAUNCH;
        end
      end
      ST_BUSY: begin
        timer_en_s = 1'b1;
        if (complete_s) begin
          next_state_s = ST_RESPOND;
        end else if (timer_done_s) begin
          next_state_s = ST_RECOVER;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_RECOVER: next_state_s = ST_RESPOND;
      ST_RESPOND: begin
        if (rsp_valid_r && RSP_READY) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESPOND;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, handshake flags and pin controls, all decoded from the next state.
  always_ff @(posedge SYSTEM_CLK or negedge RESET) begin
    if (!RESET) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b0;
      go_bar_r    <= 1'b1;
      jam_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      req_ready_r <= (next_state_s == ST_IDLE);
      go_bar_r    <= (next_state_s != ST_LAUNCH);
      jam_r       <= (next_state_s == ST_RECOVER);
      rsp_valid_r <= (next_state_s == ST_RESPOND);
    end
  end

  // Operand, left-flag and response capture registers.
  always_ff @(posedge SYSTEM_CLK or negedge RESET) begin
    if (!RESET) begin
      left_r        <= 1'b0;
      opcode_r      <= 4'h0;
      data_a_r      <= 8'h00;
      data_b_r      <= 8'h00;
      rsp_data_r    <= 8'h00;
      rsp_opcode_r  <= 4'h0;
      rsp_timeout_r <= 1'b0;
    end else begin
      if (accept_s) begin
        left_r   <= 1'b0;
        opcode_r <= REQ_OPCODE;
        data_a_r <= REQ_A;
        data_b_r <= REQ_B;
      end else if (((state_r == ST_LAUNCH) || (state_r == ST_BUSY)) &&
                   (MICROADDRESS != IDLE_UADDR)) begin
        left_r <= 1'b1;
      end
      if (complete_s) begin
        rsp_data_r    <= DATA_OUT;
        rsp_opcode_r  <= opcode_r;
        rsp_timeout_r <= 1'b0;
      end else if (state_r == ST_RECOVER) begin
        rsp_data_r    <= 8'h00;
        rsp_opcode_r  <= opcode_r;
        rsp_timeout_r <= 1'b1;
      end
    end
  end

  assign REQ_READY   = req_ready_r;
  assign GO_BAR      = go_bar_r;
  assign JAM         = jam_r;
  assign RSP_VALID   = rsp_valid_r;
  assign RSP_DATA    = rsp_data_r;
  assign RSP_OPCODE  = rsp_opcode_r;
  assign RSP_TIMEOUT = rsp_timeout_r;
  assign OPCODE      = opcode_r;
  assign DATA_IN_A   = data_a_r;
  assign DATA_IN_B   = data_b_r;

endmodule

// File: tb/tb_microprocessor_host_sequencer.sv
// Directed bench for microprocessor_host_sequencer with a behavioural
// microprocessor stub that leaves and returns to the idle microaddress.
module tb_microprocessor_host_sequencer;

  logic       SYSTEM_CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [3:0] REQ_OPCODE = 4'h0;
  logic [7:0] REQ_A = 8'h00;
  logic [7:0] REQ_B = 8'h00;
  logic       RSP_VALID;
  logic       RSP_READY = 1'b0;
  logic [7:0] RSP_DATA;
  logic [3:0] RSP_OPCODE;
  logic       RSP_TIMEOUT;
  logic [3:0] OPCODE;
  logic [7:0] DATA_IN_A, DATA_IN_B;
  logic       GO_BAR, JAM;
  logic [7:0] MICROADDRESS = 8'h00;
  logic [7:0] DATA_OUT = 8'hEE;

  int checks = 0;
  int failures = 0;

  microprocessor_host_sequencer dut (
    .SYSTEM_CLK(SYSTEM_CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OPCODE(REQ_OPCODE),
    .REQ_A(REQ_A), .REQ_B(REQ_B),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_OPCODE(RSP_OPCODE), .RSP_TIMEOUT(RSP_TIMEOUT),
    .OPCODE(OPCODE), .DATA_IN_A(DATA_IN_A), .DATA_IN_B(DATA_IN_B),
    .GO_BAR(GO_BAR), .JAM(JAM),
    .MICROADDRESS(MICROADDRESS), .DATA_OUT(DATA_OUT)
  );

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] alu_model(input logic [3:0] op,
                                           input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    case (op)
      4'b0011: return a + b;
      4'b0111: return a - b;
      4'b1100: return prod[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Stub: k counts cycles since the accept edge; microaddress is non-idle for
  // cycles 1..stub_len, then idle with the result on DATA_OUT.
  int stub_len = 0;
  bit stub_stuck = 1'b0;
  bit stub_run = 1'b0;
  int stub_k = 0;

  always @(negedge SYSTEM_CLK) begin
    if (!RESET) begin
      stub_run     = 1'b0;
      MICROADDRESS = 8'h00;
      DATA_OUT     = 8'hEE;
    end else if (!stub_run) begin
      MICROADDRESS = 8'h00;
      DATA_OUT     = 8'hEE;
      if (!GO_BAR) begin
        stub_run = 1'b1;
        stub_k   = 0;
      end
    end else begin
      stub_k = stub_k + 1;
      if (RSP_VALID || JAM) begin
        stub_run     = 1'b0;
        MICROADDRESS = 8'h00;
        DATA_OUT     = 8'hEE;
      end else if (!stub_stuck && stub_k >= 1 && stub_k <= stub_len) begin
        MICROADDRESS = 8'h20;
        DATA_OUT     = 8'hEE;
      end else begin
        MICROADDRESS = 8'h00;
        DATA_OUT     = stub_stuck ? 8'hEE : alu_model(OPCODE, DATA_IN_A, DATA_IN_B);
      end
    end
  end

  task automatic run_req(input string name, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input int len, input bit stuck,
                         input logic [7:0] exp_data, input logic exp_to,
                         input int exp_lat, input int exp_jam_at, input int hold);
    int lat, golow, jams, jam_at;
    for (int i = 0; i < 20 && !REQ_READY; i++) @(negedge SYSTEM_CLK);
    check_eq({name, ".ready_before"}, REQ_READY, 1);
    stub_len   = len;
    stub_stuck = stuck;
    REQ_VALID  = 1'b1;
    REQ_OPCODE = op;
    REQ_A      = a;
    REQ_B      = b;
    @(posedge SYSTEM_CLK);
    #1;
    REQ_VALID  = 1'b0;
    REQ_A      = 8'h5A;
    REQ_B      = 8'hA5;
    lat = -1; golow = 0; jams = 0; jam_at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge SYSTEM_CLK);
      if (i == 0) begin
        check_eq({name, ".ready_after_accept"}, REQ_READY, 0);
        check_eq({name, ".operands"}, {OPCODE, DATA_IN_A, DATA_IN_B}, {op, a, b});
      end
      if (!GO_BAR) golow++;
      if (JAM) begin
        jams++;
        jam_at = i;
      end
      if (RSP_VALID) begin
        lat = i;
        break;
      end
    end
    check_eq({name, ".latency"}, lat, exp_lat);
    check_eq({name, ".go_low_cycles"}, golow, 6);
    check_eq({name, ".jam_pulses"}, jams, (exp_jam_at < 0) ? 0 : 1);
    check_eq({name, ".jam_cycle"}, jam_at, exp_jam_at);
    check_eq({name, ".rsp_data"}, RSP_DATA, exp_data);
    check_eq({name, ".rsp_timeout"}, RSP_TIMEOUT, exp_to);
    check_eq({name, ".rsp_opcode"}, RSP_OPCODE, op);
    // Backpressure: a held request must not be taken while the response waits.
    REQ_VALID  = (hold > 0);
    REQ_OPCODE = 4'b0011;
    for (int i = 0; i < hold; i++) begin
      @(negedge SYSTEM_CLK);
      check_eq({name, ".bp_valid"}, RSP_VALID, 1);
      check_eq({name, ".bp_data"}, {RSP_DATA, RSP_OPCODE, RSP_TIMEOUT},
               {exp_data, op, exp_to});
      check_eq({name, ".bp_ready"}, REQ_READY, 0);
      check_eq({name, ".bp_opcode"}, OPCODE, op);
    end
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(posedge SYSTEM_CLK);
    #1;
    RSP_READY = 1'b0;
    @(negedge SYSTEM_CLK);
    check_eq({name, ".rsp_valid_after_hs"}, RSP_VALID, 0);
    check_eq({name, ".ready_after_hs"}, REQ_READY, 1);
  endtask

  initial begin
    repeat (3) @(negedge SYSTEM_CLK);
    check_eq("reset.go_bar", GO_BAR, 1);
    check_eq("reset.jam", JAM, 0);
    check_eq("reset.req_ready", REQ_READY, 0);
    check_eq("reset.rsp_valid", RSP_VALID, 0);
    check_eq("reset.rsp", {RSP_DATA, RSP_OPCODE, RSP_TIMEOUT}, 13'h0000);
    check_eq("reset.operands", {OPCODE, DATA_IN_A, DATA_IN_B}, 20'h00000);
    RESET = 1'b1;
    #1;
    check_eq("release.ready_before_edge", REQ_READY, 0);
    @(negedge SYSTEM_CLK);
    check_eq("release.ready_after_edge", REQ_READY, 1);

    // name, op, a, b, stub_len, stuck, data, timeout, latency, jam cycle, hold
    run_req("add",     4'b0011, 8'h14, 8'h23, 10, 1'b0, 8'h37, 1'b0, 12, -1, 0);
    run_req("sub",     4'b0111, 8'h81, 8'h41, 10, 1'b0, 8'h40, 1'b0, 12, -1, 10);
    run_req("mul",     4'b1100, 8'h05, 8'h07, 20, 1'b0, 8'h23, 1'b0, 22, -1, 0);
    run_req("minlat",  4'b0011, 8'hF0, 8'h20,  5, 1'b0, 8'h10, 1'b0,  7, -1, 2);
    run_req("timeout", 4'b0111, 8'h10, 8'h01,  0, 1'b1, 8'h00, 1'b1, 65, 64, 3);
    run_req("coincide", 4'b1100, 8'h0C, 8'h0B, 62, 1'b0, 8'h84, 1'b0, 64, -1, 0);

    // Reset in the middle of LAUNCH discards the operation.
    @(negedge SYSTEM_CLK);
    stub_len   = 10;
    stub_stuck = 1'b0;
    REQ_VALID  = 1'b1;
    REQ_OPCODE = 4'b0011;
    REQ_A      = 8'h01;
    REQ_B      = 8'h02;
    @(posedge SYSTEM_CLK);
    #1;
    REQ_VALID = 1'b0;
    @(posedge SYSTEM_CLK);
    #1;
    check_eq("midreset.go_bar_before", GO_BAR, 0);
    RESET = 1'b0;
    #1;
    check_eq("midreset.go_bar", GO_BAR, 1);
    check_eq("midreset.rsp_valid", RSP_VALID, 0);
    check_eq("midreset.req_ready", REQ_READY, 0);
    check_eq("midreset.opcode", OPCODE, 4'h0);
    @(negedge SYSTEM_CLK);
    RESET = 1'b1;
    @(negedge SYSTEM_CLK);
    check_eq("midreset.ready_after_release", REQ_READY, 1);
    repeat (20) @(negedge SYSTEM_CLK);
    check_eq("midreset.no_response", RSP_VALID, 0);
    check_eq("midreset.go_bar_idle", GO_BAR, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
